crc_frame_serializer: RTL and testbench

- Byte-to-bit serializer that sits directly upstream of the team's serial CRC-16 generator (x^16+x^12+x^5+1, zero init, MSB-first).
- Accepts a frame of bytes over a valid/ready handshake and emits them MSB-first as a timed bit stream.
- Drives the generator's bit, enable and clear inputs, then appends the generator's 16-bit result (MSB first) to the stream.
- Used for the sector-header/data serialization path feeding the drive/bus emulation logic.

---
 rtl/crc_frame_serializer_if.sv | 31 +++
 rtl/crc_frame_serializer.sv | 259 +++++++++++++++++++++++++
 tb/tb_crc_frame_serializer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_serializer_if.sv
// crc_frame_serializer_if: groups the handshake, serial-stream and CRC-generator
// signals of crc_frame_serializer.
//   slave  : the serializer (consumes start/abort/bytes/crc_in, drives the rest)
//   master : the environment (byte source, bit-stream sink, CRC generator)
interface crc_frame_serializer_if;
  logic        start;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        ser_bit;
  logic        ser_strobe;
  logic        crc_bit;
  logic        crc_en;
  logic        crc_clr;
  logic [15:0] crc_in;
  logic        busy;
  logic        done;
  logic        underrun;

  modport slave (
    input  start, abort, byte_in, byte_valid, byte_last, crc_in,
    output byte_ready, ser_bit, ser_strobe, crc_bit, crc_en, crc_clr, busy, done, underrun
  );

  modport master (
    output start, abort, byte_in, byte_valid, byte_last, crc_in,
    input  byte_ready, ser_bit, ser_strobe, crc_bit, crc_en, crc_clr, busy, done, underrun
  );
endinterface

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: byte-to-bit serializer feeding an external serial CRC-16
// generator (x^16+x^12+x^5+1, zero init, MSB first). A frame of bytes is taken over
// a valid/ready handshake and emitted MSB first, one bit per BIT_CYCLES-cycle cell,
// followed by the 16-bit CRC read back from the generator.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus_io : crc_frame_serializer_if.slave
//            start/abort           frame control
//            byte_in/valid/last    byte stream in, byte_ready back-pressure
//            ser_bit/ser_strobe    timed bit stream out
//            crc_bit/en/clr,crc_in generator drive and readback
//            busy/done/underrun    status (underrun sticky until next start)
//
// Configuration macro: CRC_FEEDBACK_EN
//   defined   - CRC cells are also fed to the generator, leaving a zero residue.
//   undefined - generator is idle during CRC cells and keeps the frame CRC.
//
// All outputs come straight from flops.
module crc_frame_serializer #(
  parameter int unsigned BIT_CYCLES = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  crc_frame_serializer_if.slave  bus_io
);

  typedef enum logic [2:0] {StIdle, StClear, StData, StCrc, StFin} state_e;

  localparam logic [CNT_W-1:0] CellLast = CNT_W'(BIT_CYCLES - 1);

  state_e state_q, state_d;

  // Current cell / shifter
  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             cur_last_q, cur_last_d;
  // One-byte hold register
  logic [7:0]       hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             hold_last_q, hold_last_d;
  logic             last_acc_q, last_acc_d;
  logic [15:0]      crc_q, crc_d;
  logic             underrun_q, underrun_d;

  // Registered outputs
  logic byte_ready_q, byte_ready_d;
  logic ser_bit_q, ser_bit_d;
  logic ser_strobe_q, ser_strobe_d;
  logic crc_bit_q, crc_bit_d;
  logic crc_en_q, crc_en_d;
  logic crc_clr_q, crc_clr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic       new_cell;
  logic       new_bit;
  logic       abort_take;
  logic       cell_end;
  logic       hs;
  logic       load_direct;
  logic [3:0] bit_nxt;

  assign cell_end = active_q && (cnt_q == CellLast);
  assign hs       = (state_q == StData) && byte_ready_q && bus_io.byte_valid && !bus_io.abort;
  assign bit_nxt  = bit_q - 4'd1;
  // Shifter free right now (starved, or just finishing bit 0 with nothing queued):
  // an accepted byte bypasses the hold register so the stream has no gap.
  assign load_direct = hs && (!active_q ||
                              (cell_end && (bit_q == 4'd0) && !hold_valid_q && !cur_last_q));

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      active_q     <= 1'b0;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      cur_last_q   <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      last_acc_q   <= 1'b0;
      crc_q        <= '0;
      underrun_q   <= 1'b0;
      byte_ready_q <= 1'b0;
      ser_bit_q    <= 1'b0;
      ser_strobe_q <= 1'b0;
      crc_bit_q    <= 1'b0;
      crc_en_q     <= 1'b0;
      crc_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      cur_last_q   <= cur_last_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      last_acc_q   <= last_acc_d;
      crc_q        <= crc_d;
      underrun_q   <= underrun_d;
      byte_ready_q <= byte_ready_d;
      ser_bit_q    <= ser_bit_d;
      ser_strobe_q <= ser_strobe_d;
      crc_bit_q    <= crc_bit_d;
      crc_en_q     <= crc_en_d;
      crc_clr_q    <= crc_clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic
  always_comb begin : next_state_comb
    state_d      = state_q;
    active_d     = active_q;
    cnt_d        = active_q ? cnt_q + 1'b1 : '0;
    bit_d        = bit_q;
    sh_d         = sh_q;
    cur_last_d   = cur_last_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    last_acc_d   = last_acc_q;
    crc_d        = crc_q;
    underrun_d   = underrun_q;
    new_cell     = 1'b0;
    new_bit      = 1'b0;
    abort_take   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d      = StClear;
          active_d     = 1'b0;
          cnt_d        = '0;
          hold_valid_d = 1'b0;
          last_acc_d   = 1'b0;
          underrun_d   = 1'b0;
        end
      end

      StClear: state_d = StData;

      StData: begin
        if (hs) begin
          last_acc_d = last_acc_q | bus_io.byte_last;
        end
        if (load_direct) begin
          sh_d       = bus_io.byte_in;
          cur_last_d = bus_io.byte_last;
          bit_d      = 4'd7;
          active_d   = 1'b1;
          cnt_d      = '0;
          new_cell   = 1'b1;
          new_bit    = bus_io.byte_in[7];
        end else if (cell_end && (bit_q != 4'd0)) begin
          bit_d    = bit_nxt;
          cnt_d    = '0;
          new_cell = 1'b1;
          new_bit  = sh_q[bit_nxt[2:0]];
        end else if (cell_end && cur_last_q) begin
          // Generator took the bit-0 strobe at least one cycle ago, so crc_in is final.
          state_d  = StCrc;
          crc_d    = bus_io.crc_in;
          bit_d    = 4'd15;
          cnt_d    = '0;
          new_cell = 1'b1;
          new_bit  = bus_io.crc_in[15];
        end else if (cell_end && hold_valid_q) begin
          sh_d         = hold_q;
          cur_last_d   = hold_last_q;
          hold_valid_d = 1'b0;
          bit_d        = 4'd7;
          cnt_d        = '0;
          new_cell     = 1'b1;
          new_bit      = hold_q[7];
        end else if (cell_end) begin
          active_d   = 1'b0;
          cnt_d      = '0;
          underrun_d = 1'b1;
        end
        if (hs && !load_direct) begin
          hold_d       = bus_io.byte_in;
          hold_valid_d = 1'b1;
          hold_last_d  = bus_io.byte_last;
        end
      end

      StCrc: begin
        if (cell_end) begin
          if (bit_q != 4'd0) begin
            bit_d    = bit_nxt;
            cnt_d    = '0;
            new_cell = 1'b1;
            new_bit  = crc_q[bit_nxt];
          end else begin
            state_d  = StFin;
            active_d = 1'b0;
            cnt_d    = '0;
          end
        end
      end

      StFin: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a handshake in the same cycle.
    if (bus_io.abort && (state_q != StIdle)) begin
      state_d      = StIdle;
      active_d     = 1'b0;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
      last_acc_d   = 1'b0;
      new_cell     = 1'b0;
      new_bit      = 1'b0;
      abort_take   = 1'b1;
    end
  end

  // Output logic: computed from the next state so the output flops line up with state_q.
  always_comb begin : output_comb
    busy_d       = (state_d == StClear) || (state_d == StData) || (state_d == StCrc);
    done_d       = (state_d == StFin);
    crc_clr_d    = (state_d == StClear) || abort_take;
    byte_ready_d = (state_d == StData) && !hold_valid_d && !last_acc_d;
    ser_strobe_d = new_cell;
    ser_bit_d    = new_cell ? new_bit : (active_d & ser_bit_q);
`ifdef CRC_FEEDBACK_EN
    crc_en_d     = new_cell;
`else
    crc_en_d     = new_cell && (state_d == StData);
`endif
    crc_bit_d    = crc_en_d & new_bit;
  end

  assign bus_io.byte_ready = byte_ready_q;
  assign bus_io.ser_bit    = ser_bit_q;
  assign bus_io.ser_strobe = ser_strobe_q;
  assign bus_io.crc_bit    = crc_bit_q;
  assign bus_io.crc_en     = crc_en_q;
  assign bus_io.crc_clr    = crc_clr_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.done       = done_q;
  assign bus_io.underrun   = underrun_q;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Bench for crc_frame_serializer: directed + randomized frames against a reference
// built from the byte list (expected bit stream and CRC-16/XMODEM of the data).
module tb_crc_frame_serializer;
  localparam int unsigned BC = 2;
`ifdef CRC_FEEDBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  crc_frame_serializer_if ifc ();

  crc_frame_serializer #(.BIT_CYCLES(BC), .CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (ifc)
  );

  always #5 clk = ~clk;

  // External serial CRC generator model, cleared by crc_clr
  logic [15:0] gen_q = '0;
  always @(posedge clk) begin
    if (ifc.crc_clr) gen_q <= '0;
    else if (ifc.crc_en)
      gen_q <= {gen_q[14:0], 1'b0} ^ ((gen_q[15] ^ ifc.crc_bit) ? 16'h1021 : 16'h0000);
  end
  assign ifc.crc_in = gen_q;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  bit   got_q[$];
  int   strobes = 0, done_cnt = 0, done_cyc = 0, last_str = 0, prev_str = -1;
  int   max_gap = 0, clr_cnt = 0, en_bad = 0, cur_n = 0;
  logic [7:0]  fb_bytes[16];
  logic [15:0] got_crc;

  always @(negedge clk) begin
    if (ifc.ser_strobe) begin
      logic exp_en;
      exp_en = (strobes < 8 * cur_n) || FB;
      if (ifc.crc_en !== exp_en || (exp_en && ifc.crc_bit !== ifc.ser_bit)) en_bad++;
      if (prev_str >= 0 && cyc - prev_str > max_gap) max_gap = cyc - prev_str;
      prev_str = cyc;
      last_str = cyc;
      got_q.push_back(ifc.ser_bit);
      strobes++;
    end else if (ifc.crc_en) begin
      en_bad++;
    end
    if (ifc.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ifc.crc_clr) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16_ref(input int nb);
    logic [15:0] c;
    logic f;
    c = '0;
    for (int i = 0; i < nb; i++) begin
      for (int j = 7; j >= 0; j--) begin
        f = c[15] ^ fb_bytes[i][j];
        c = {c[14:0], 1'b0};
        if (f) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic [8:0] out_vec();
    return {ifc.busy, ifc.done, ifc.ser_bit, ifc.ser_strobe, ifc.byte_ready,
            ifc.crc_en, ifc.crc_bit, ifc.crc_clr, ifc.underrun};
  endfunction

  task automatic clear_mon(input int nb);
    @(posedge clk);
    #1;
    cur_n = nb;
    got_q.delete();
    strobes = 0; done_cnt = 0; max_gap = 0; prev_str = -1; clr_cnt = 0; en_bad = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int w;
    w = 0;
    @(negedge clk);
    ifc.byte_in = b; ifc.byte_last = last; ifc.byte_valid = 1'b1;
    while (ifc.byte_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", (w < 1000), 1);
    @(posedge clk);
    #1;
    ifc.byte_valid = 1'b0; ifc.byte_last = 1'b0;
  endtask

  task automatic run_frame(input int nb, input int late_at, input int late_gap,
                           input int max_rgap, input bit poke_start, input logic exp_under);
    int w, mism;
    logic [15:0] rc;
    clear_mon(nb);
    pulse_start();
    check("clear_pulse", ifc.crc_clr, 1);
    check("busy_clear", ifc.busy, 1);
    for (int i = 0; i < nb; i++) begin
      if (i == late_at) repeat (late_gap) @(negedge clk);
      else if (max_rgap > 0) repeat ($urandom_range(max_rgap, 0)) @(negedge clk);
      send_byte(fb_bytes[i], (i == nb - 1));
      if (poke_start && i == 0) begin
        pulse_start();
        check("busy_poke", ifc.busy, 1);
      end
    end
    w = 0;
    while (done_cnt == 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", (done_cnt > 0), 1);
    repeat (3) @(negedge clk);
    rc = crc16_ref(nb);
    mism = 0;
    for (int k = 0; k < got_q.size() && k < 8 * nb; k++)
      if (got_q[k] !== fb_bytes[k / 8][7 - (k % 8)]) mism++;
    got_crc = '0;
    if (got_q.size() >= 16)
      for (int k = 0; k < 16; k++) got_crc = {got_crc[14:0], got_q[got_q.size() - 16 + k]};
    check("strobe_count", strobes, 8 * nb + 16);
    check("data_bits", mism, 0);
    check("crc_word", got_crc, rc);
    check("done_count", done_cnt, 1);
    check("done_timing", done_cyc - last_str, BC);
    check("crc_en_pattern", en_bad, 0);
    check("clr_count", clr_cnt, 1);
    check("underrun", ifc.underrun, exp_under);
    check("gen_residue", gen_q, FB ? 16'h0000 : rc);
    check("busy_after", ifc.busy, 0);
    check("ready_after", ifc.byte_ready, 0);
    if (late_at < 0) check("even_spacing", max_gap, BC);
    else check("stall_seen", (max_gap > BC), 1);
  endtask

  initial begin
    int w, s_abort;
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.byte_in = '0;
    ifc.byte_valid = 1'b0; ifc.byte_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", out_vec(), 0);

    // byte_valid ignored in IDLE
    ifc.byte_valid = 1'b1; ifc.byte_in = 8'h55;
    repeat (5) @(negedge clk);
    check("idle_ready", ifc.byte_ready, 0);
    check("idle_no_strobe", strobes, 0);
    ifc.byte_valid = 1'b0;

    // Single byte 0x01
    fb_bytes[0] = 8'h01;
    run_frame(1, -1, 0, 0, 1'b0, 1'b0);
    check("crc_0x01", got_crc, 16'h1021);

    // "123456789" back to back
    for (int i = 0; i < 9; i++) fb_bytes[i] = 8'h31 + 8'(i);
    run_frame(9, -1, 0, 0, 1'b0, 1'b0);
    check("crc_check_str", got_crc, 16'h31C3);

    // Late second byte -> starvation
    for (int i = 0; i < 3; i++) fb_bytes[i] = 8'($urandom);
    run_frame(3, 1, 40, 0, 1'b0, 1'b1);

    // Next frame clears sticky underrun; start pulsed mid-frame is ignored
    for (int i = 0; i < 2; i++) fb_bytes[i] = 8'($urandom);
    run_frame(2, -1, 0, 0, 1'b1, 1'b0);

    // Abort during the 3rd data byte
    clear_mon(4);
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    w = 0;
    while (strobes < 18 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("abort_reach", (strobes >= 18), 1);
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    check("abort_busy", ifc.busy, 0);
    check("abort_clr", ifc.crc_clr, 1);
    check("abort_ready", ifc.byte_ready, 0);
    s_abort = strobes;
    @(negedge clk);
    check("abort_clr_end", ifc.crc_clr, 0);
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_quiet", strobes, s_abort);
    fb_bytes[0] = 8'h01;
    run_frame(1, -1, 0, 0, 1'b0, 1'b0);
    check("crc_after_abort", got_crc, 16'h1021);

    // Reset during the CRC phase
    clear_mon(1);
    pulse_start();
    send_byte(8'hA5, 1'b1);
    w = 0;
    while (strobes < 12 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("crc_phase_reach", ifc.busy, 1);
    #2 reset = 1'b1;
    #1 check("reset_mid_crc", out_vec(), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("reset_no_done", done_cnt, 0);
    check("reset_idle", out_vec(), 0);

    // Random frames with small inter-byte gaps
    for (int f = 0; f < 4; f++) begin
      int nb;
      nb = $urandom_range(5, 1);
      for (int i = 0; i < nb; i++) fb_bytes[i] = 8'($urandom);
      run_frame(nb, -1, 0, 3, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
